// File: rtl/fifo_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fill_pkg
// Description : Shared state encodings and constants for the FIFO fill
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITING    = 2'd1,
        ST_WAIT_STOP  = 2'd2,
        ST_WAIT_DRAIN = 2'd3
    } fill_state_t;

    localparam int MODE_CONST = 0;
    localparam int MODE_INC   = 1;
    localparam int MODE_ALT   = 2;

    localparam int WR_COUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/fill_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : fill_pattern_gen
// Description : Write-data pattern register; steps to the next word on adv.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_pattern_gen
    import fifo_fill_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                MODE    = MODE_CONST,
    parameter logic [DATA_W-1:0] PATTERN = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_next;

    generate
        if (MODE == MODE_INC) begin : g_inc
            assign w_next = r_data + DATA_W'(1);
        end else if (MODE == MODE_ALT) begin : g_alt
            assign w_next = ~r_data;
        end else if (MODE == MODE_CONST) begin : g_const
            assign w_next = r_data;
        end else begin : g_bad_mode
            $error("fill_pattern_gen: unsupported MODE %0d", MODE);
            assign w_next = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= PATTERN;
        end else if (adv) begin
            r_data <= w_next;
        end
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/fifo_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fill_ctrl
// Description : Keeps a downstream FIFO filled between two watermarks.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_fill_ctrl
    import fifo_fill_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                CNT_W       = 4,
    parameter int                HIGH_MARK   = 5,
    parameter int                LOW_MARK    = 2,
    parameter int                STOP_CYCLES = 1,
    parameter int                MODE        = MODE_CONST,
    parameter logic [DATA_W-1:0] PATTERN     = 8'hAA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_W-1:0]      fifo_words,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [DATA_W-1:0]     fifo_data,
    output logic [1:0]            state,
    output logic [WR_COUNT_W-1:0] wr_count
);

    localparam int                c_stop_w    = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
    localparam logic [c_stop_w-1:0] c_stop_load = c_stop_w'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_high      = CNT_W'(HIGH_MARK);
    localparam logic [CNT_W-1:0]    c_low       = CNT_W'(LOW_MARK);

    generate
        if (!(LOW_MARK >= 0 && LOW_MARK < HIGH_MARK && HIGH_MARK <= (2**CNT_W) - 1)) begin : g_bad_marks
            $error("fifo_fill_ctrl: need 0 <= LOW_MARK < HIGH_MARK <= 2**CNT_W-1");
        end
        if (STOP_CYCLES < 1) begin : g_bad_stop
            $error("fifo_fill_ctrl: STOP_CYCLES must be at least 1");
        end
    endgenerate

    fill_state_t         r_state;
    fill_state_t         w_state_nxt;
    logic [c_stop_w-1:0] r_stop_cnt;
    logic [c_stop_w-1:0] w_stop_cnt_nxt;
    logic [WR_COUNT_W-1:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
        end
    end

    // The high-mark check in WRITING outranks en so a full FIFO always drains first.
    always_comb begin
        w_state_nxt    = r_state;
        w_stop_cnt_nxt = r_stop_cnt;
        case (r_state)
            ST_IDLE: begin
                if (en && (fifo_words < c_high)) begin
                    w_state_nxt = ST_WRITING;
                end
            end
            ST_WRITING: begin
                if (fifo_words >= c_high) begin
                    w_state_nxt    = ST_WAIT_STOP;
                    w_stop_cnt_nxt = c_stop_load;
                end else if (!en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_STOP: begin
                if (r_stop_cnt == '0) begin
                    w_state_nxt = ST_WAIT_DRAIN;
                end else begin
                    w_stop_cnt_nxt = r_stop_cnt - c_stop_w'(1);
                end
            end
            ST_WAIT_DRAIN: begin
                if (fifo_words <= c_low) begin
                    w_state_nxt = en ? ST_WRITING : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wr_en = (r_state == ST_WRITING) && !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (wr_en) begin
            r_wr_count <= r_wr_count + WR_COUNT_W'(1);
        end
    end

    fill_pattern_gen #(
        .DATA_W  (DATA_W),
        .MODE    (MODE),
        .PATTERN (PATTERN)
    ) u_pattern (
        .clk  (clk),
        .rst  (rst),
        .adv  (wr_en),
        .data (fifo_data)
    );

    assign state    = r_state;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_fill_ctrl
// Description : Self-checking bench for fifo_fill_ctrl, three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_fill_ctrl;

    localparam int          HIGH_A [3] = '{5, 5, 12};
    localparam int          LOW_A  [3] = '{2, 2, 4};
    localparam int          STOP_A [3] = '{1, 3, 2};
    localparam int          MODE_A [3] = '{0, 1, 2};
    localparam logic [7:0]  PAT_A  [3] = '{8'hAA, 8'hFE, 8'h5C};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       full;
    logic [3:0] words;

    logic        wr0, wr1, wr2;
    logic [7:0]  d0, d1, d2;
    logic [1:0]  s0, s1, s2;
    logic [15:0] c0, c1, c2;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    fifo_fill_ctrl #(.DATA_W(8), .CNT_W(4), .HIGH_MARK(5), .LOW_MARK(2),
                     .STOP_CYCLES(1), .MODE(0), .PATTERN(8'hAA)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .fifo_words(words), .fifo_full(full),
        .wr_en(wr0), .fifo_data(d0), .state(s0), .wr_count(c0));

    fifo_fill_ctrl #(.DATA_W(8), .CNT_W(4), .HIGH_MARK(5), .LOW_MARK(2),
                     .STOP_CYCLES(3), .MODE(1), .PATTERN(8'hFE)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .fifo_words(words), .fifo_full(full),
        .wr_en(wr1), .fifo_data(d1), .state(s1), .wr_count(c1));

    fifo_fill_ctrl #(.DATA_W(8), .CNT_W(4), .HIGH_MARK(12), .LOW_MARK(4),
                     .STOP_CYCLES(2), .MODE(2), .PATTERN(8'h5C)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .fifo_words(words), .fifo_full(full),
        .wr_en(wr2), .fifo_data(d2), .state(s2), .wr_count(c2));

    logic        a_wr [3];
    logic [7:0]  a_d  [3];
    logic [1:0]  a_s  [3];
    logic [15:0] a_c  [3];
    assign a_wr[0] = wr0; assign a_wr[1] = wr1; assign a_wr[2] = wr2;
    assign a_d[0]  = d0;  assign a_d[1]  = d1;  assign a_d[2]  = d2;
    assign a_s[0]  = s0;  assign a_s[1]  = s1;  assign a_s[2]  = s2;
    assign a_c[0]  = c0;  assign a_c[1]  = c1;  assign a_c[2]  = c2;

    // Reference: state as a plain number, cycles already spent waiting, and
    // the total number of writes; the data word is derived from that total.
    int          m_state [3];
    int          m_waited[3];
    logic [15:0] m_cnt   [3];

    function automatic logic exp_wr(int k);
        return (m_state[k] == 1) && !full;
    endfunction

    function automatic logic [7:0] exp_data(int k);
        logic [7:0] low;
        low = m_cnt[k][7:0];
        case (MODE_A[k])
            0:       return PAT_A[k];
            1:       return PAT_A[k] + low;
            default: return m_cnt[k][0] ? ~PAT_A[k] : PAT_A[k];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic w;
            int   nw;
            w  = exp_wr(k);
            nw = int'(words);
            if (rst) begin
                m_state[k]  = 0;
                m_waited[k] = 0;
                m_cnt[k]    = 16'd0;
            end else begin
                if (w) m_cnt[k] = m_cnt[k] + 16'd1;
                case (m_state[k])
                    0: if (en && nw < HIGH_A[k]) m_state[k] = 1;
                    1: begin
                        if (nw >= HIGH_A[k]) begin
                            m_state[k]  = 2;
                            m_waited[k] = 0;
                        end else if (!en) begin
                            m_state[k] = 0;
                        end
                    end
                    2: begin
                        m_waited[k] = m_waited[k] + 1;
                        if (m_waited[k] >= STOP_A[k]) m_state[k] = 3;
                    end
                    default: if (nw <= LOW_A[k]) m_state[k] = en ? 1 : 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("state%0d", k),   32'(a_s[k]),  32'(m_state[k]));
                chk($sformatf("wr_en%0d", k),   32'(a_wr[k]), 32'(exp_wr(k)));
                chk($sformatf("data%0d", k),    32'(a_d[k]),  32'(exp_data(k)));
                chk($sformatf("wr_count%0d", k), 32'(a_c[k]), 32'(m_cnt[k]));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; full = 1'b0; words = 4'd0;
        next();
        checking = 1'b1;
        mid();
        chk("lit_reset_state", 32'(s0), 32'd0);
        chk("lit_reset_wr", 32'(wr0), 32'd0);
        chk("lit_reset_data", 32'(d0), 32'hAA);
        chk("lit_reset_count", 32'(c0), 32'd0);
        next(); rst = 1'b0;
        mid();
        chk("lit_idle_before_start", 32'(s0), 32'd0);

        next(); mid();
        chk("lit_first_state", 32'(s0), 32'd1);
        chk("lit_first_wr", 32'(wr0), 32'd1);
        chk("lit_first_data", 32'(d0), 32'hAA);
        chk("lit_inc_fe", 32'(d1), 32'hFE);
        next(); mid();
        chk("lit_inc_ff", 32'(d1), 32'hFF);
        next(); mid();
        chk("lit_inc_00", 32'(d1), 32'h00);
        next(); full = 1'b1;
        mid();
        chk("lit_full_data", 32'(d1), 32'h01);
        chk("lit_full_wr", 32'(wr1), 32'd0);
        chk("lit_full_count", 32'(c1), 32'd3);
        next(); mid();
        chk("lit_full2_data", 32'(d1), 32'h01);
        chk("lit_full2_count", 32'(c1), 32'd3);
        next(); full = 1'b0;
        mid();
        chk("lit_unfull_wr", 32'(wr1), 32'd1);
        chk("lit_unfull_data", 32'(d1), 32'h01);

        for (int k = 1; k <= 5; k++) begin
            next(); words = 4'(k);
        end
        mid();
        chk("lit_high_seen_wr", 32'(wr0), 32'd1);
        next(); words = 4'd3;
        mid();
        chk("lit_stop_state0", 32'(s0), 32'd2);
        chk("lit_stop_wr0", 32'(wr0), 32'd0);
        chk("lit_stop_state1_a", 32'(s1), 32'd2);
        next(); mid();
        chk("lit_drain_state0_a", 32'(s0), 32'd3);
        chk("lit_stop_state1_b", 32'(s1), 32'd2);
        next(); mid();
        chk("lit_drain_state0_b", 32'(s0), 32'd3);
        chk("lit_stop_state1_c", 32'(s1), 32'd2);
        next(); mid();
        chk("lit_drain_state1", 32'(s1), 32'd3);
        next(); words = 4'd2;
        mid();
        chk("lit_drain_hold_at2", 32'(s0), 32'd3);
        next(); mid();
        chk("lit_resume0", 32'(s0), 32'd1);
        chk("lit_resume1", 32'(s1), 32'd1);

        next(); words = 4'd5;
        next(); words = 4'd3; en = 1'b0;
        next();
        next(); words = 4'd2;
        next(); mid();
        chk("lit_drain_to_idle", 32'(s0), 32'd0);

        next(); en = 1'b1; words = 4'd0;
        next(); mid();
        chk("lit_rewrite", 32'(s0), 32'd1);
        next(); rst = 1'b1;
        next(); rst = 1'b0;
        mid();
        chk("lit_rst_state", 32'(s0), 32'd0);
        chk("lit_rst_count", 32'(c0), 32'd0);
        chk("lit_rst_data1", 32'(d1), 32'hFE);
        chk("lit_rst_wr", 32'(wr0), 32'd0);
        next(); mid();
        chk("lit_rst_resume", 32'(s0), 32'd1);
        chk("lit_rst_resume_wr", 32'(wr0), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            next();
            rst  = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 9) != 0);
            full = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) words = 4'($urandom_range(0, 15));
        end
        mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_fill_ctrl.md
# fifo_fill_ctrl

Parametrised write-side flow controller that keeps a downstream FIFO topped up between two watermarks. It drives `wr_en` and a generated data word into the FIFO write port and watches the FIFO's occupancy count. Compared with the fixed 8-bit, constant-0xAA filler, it adds:
- configurable width and thresholds;
- a selectable data pattern;
- an enable and idle state;
- full-flag gating;
- a programmable stop-wait;
- a write counter for bring-up and debug.

## Interface
Parameters:
- `DATA_W`, 8: width of `fifo_data`.
- `CNT_W`, 4: width of `fifo_words`.
- `HIGH_MARK`, 5: stop writing when `fifo_words >= HIGH_MARK`.
- `LOW_MARK`, 2: resume when `fifo_words <= LOW_MARK`. Legal range is `LOW_MARK < HIGH_MARK <= 2**CNT_W-1`; elaboration fails otherwise.
- `STOP_CYCLES`, 1: cycles spent in WAIT_STOP (≥1). This covers the FIFO count pipeline lag.
- `MODE`, 0: data pattern. 0 = constant, 1 = incrementing, 2 = alternating `PATTERN`/`~PATTERN`.
- `PATTERN`, 8'hAA: constant value, and the seed for modes 1 and 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run enable.
- `fifo_words` input CNT_W: FIFO occupancy.
- `fifo_full` input 1: FIFO full flag.
- `wr_en` output 1: FIFO write strobe.
- `fifo_data` output DATA_W: write data.
- `state` output 2: current FSM state, for debug.
- `wr_count` output 16: number of writes issued; wraps modulo 2^16.

## Operation
- States: IDLE=0, WRITING=1, WAIT_STOP=2, WAIT_DRAIN=3. Unused encodings fall to IDLE.
- **IDLE:**
  - `en && fifo_words < HIGH_MARK` → WRITING.
  - Otherwise stay in IDLE.
- **WRITING:**
  - `fifo_words >= HIGH_MARK` → WAIT_STOP. This takes priority over `en`.
  - Else if `!en` → IDLE.
  - Else stay in WRITING.
- **WAIT_STOP:**
  - Load the stop counter with `STOP_CYCLES-1` on entry.
  - Leave for WAIT_DRAIN when the counter is 0.
  - `en` is ignored in this state.
- **WAIT_DRAIN:**
  - `fifo_words <= LOW_MARK` → WRITING if `en`, else IDLE.
  - Otherwise stay in WAIT_DRAIN.
- Write strobe: `wr_en = (state==WRITING) & ~fifo_full`. The write fires only when both terms are true.
- Data pattern register holds the current word and advances only on cycles with `wr_en=1`:
  - Mode 0: constant.
  - Mode 1: +1, wrapping mod 2^DATA_W.
  - Mode 2: bitwise invert.
- `fifo_data` always presents the current pattern register value.
- `wr_count` increments by 1 on each `wr_en=1` cycle.
- Comparisons on `fifo_words` are unsigned, at CNT_W width.

## Timing
- Reset values: `state`=IDLE, `wr_en`=0, `fifo_data`=PATTERN, `wr_count`=0, stop counter=0.
- Reset asserted mid-operation returns to IDLE on the next edge. `wr_en` drops in the cycle after that edge. The pattern is re-seeded.
- `en` sampled high at edge N (in IDLE) → state=WRITING and `wr_en`=1 in the cycle following edge N.
- `fifo_words >= HIGH_MARK` sampled at edge N → `wr_en`=0 from the cycle after N.
- WAIT_STOP lasts exactly STOP_CYCLES cycles. WAIT_DRAIN begins on the next edge.
- `fifo_full` acts combinationally within the same cycle. The pattern and `wr_count` hold while full.
- `fifo_words` crossing both marks in the same cycle: only the current state's compare applies.
- In WAIT_DRAIN with `fifo_words <= LOW_MARK` already true on entry: exactly one cycle is spent in WAIT_DRAIN.

## Structure
- Package `fifo_fill_pkg`:
  - state encodings;
  - MODE constants (MODE_CONST, MODE_INC, MODE_ALT);
  - `wr_count` width constant (16).
- Sub-module `fill_pattern_gen`, parameterised by DATA_W, MODE and PATTERN:
  - Inputs: `clk`, `rst`, `adv`.
  - Output: `data`.
  - The top level drives `adv = wr_en`.
- Top level holds the FSM, the stop counter and `wr_count`.

## Test plan
- Reset, then `en`=1 with `fifo_words`=0 (defaults):
  - WRITING from the first post-reset cycle;
  - `fifo_data`=0xAA;
  - `wr_en`=1.
- Ramp `fifo_words` 0→5:
  - `wr_en`=0 the cycle after 5 is sampled;
  - exactly 1 WAIT_STOP cycle;
  - WAIT_DRAIN holds at 3;
  - WRITING resumes the cycle after 2 is sampled.
- MODE=1, PATTERN=8'hFE: successive writes give FE, FF, 00, 01.
  - Assert `fifo_full` for 2 cycles mid-run: `wr_en`=0, data holds, `wr_count` is unchanged.
- STOP_CYCLES=3:
  - WAIT_STOP lasts 3 cycles, even if `fifo_words` drops to 0 during it.
  - `en` deasserted during WAIT_DRAIN: IDLE reached once `fifo_words` ≤ 2.
- `rst` pulsed while in WRITING:
  - IDLE next cycle;
  - `wr_count`=0;
  - `fifo_data`=PATTERN;
  - with `en` held high, WRITING re-entered one cycle after reset releases.
